// File: rtl/skip_decoder.sv
// Skip-ring receive monitor: recovers the per-slot pass/skip mask from oversampled
// reference, skipped-clock and ring-start inputs, and publishes one mask per frame.
module skip_decoder #(
  parameter int unsigned LEN  = 16,
  parameter int unsigned WIN  = 4,
  parameter int unsigned SYNC = 2
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  input  logic           iE,
  input  logic           iCLR,
  input  logic           iREF,
  input  logic           iSCLK,
  input  logic           iST,
  output logic [LEN-1:0] oMASK,
  output logic           oVALID,
  output logic           oCHG,
  output logic           oLOCK,
  output logic           oERR
);

  localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int unsigned CNT_W = $clog2(WIN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);

  typedef enum logic {SEEK, CAPT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SYNC-1:0]  r_ref_sync;
  logic [SYNC-1:0]  r_sclk_sync;
  logic [SYNC-1:0]  r_st_sync;
  logic             r_ref_prev;
  logic             r_sclk_prev;
  logic             r_win_open;
  logic [CNT_W-1:0] r_win_cnt;
  logic             r_pass;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [LEN-1:0]   r_frame;
  logic [LEN-1:0]   w_mask;
  logic             w_ref_ev;
  logic             w_sclk_ev;
  logic             w_st;
  logic             w_close;
  logic             w_bit;
  logic             w_stray;
  logic             w_early;
  logic             w_frame_fault;
  logic             w_publish;
  logic             w_fault;

  // Synchronizers and edge history run even while disabled so no stale edge fires on re-enable.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_ref_sync  <= '0;
      r_sclk_sync <= '0;
      r_st_sync   <= '0;
      r_ref_prev  <= 1'b0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_ref_sync  <= SYNC'({r_ref_sync, iREF});
      r_sclk_sync <= SYNC'({r_sclk_sync, iSCLK});
      r_st_sync   <= SYNC'({r_st_sync, iST});
      r_ref_prev  <= r_ref_sync[SYNC-1];
      r_sclk_prev <= r_sclk_sync[SYNC-1];
    end
  end

  assign w_ref_ev  = iE & r_ref_sync[SYNC-1] & ~r_ref_prev;
  assign w_sclk_ev = iE & r_sclk_sync[SYNC-1] & ~r_sclk_prev;
  assign w_st      = r_st_sync[SYNC-1];

  // A skipped-clock edge on the reference-edge cycle belongs to the window it opens.
  assign w_early = w_ref_ev & r_win_open;
  assign w_close = iE & r_win_open & (w_ref_ev | (r_win_cnt == LAST_CNT));
  assign w_bit   = r_pass | (w_sclk_ev & ~w_ref_ev);
  assign w_stray = w_sclk_ev & ~w_ref_ev & ~r_win_open;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_win_open <= 1'b0;
      r_win_cnt  <= '0;
      r_pass     <= 1'b0;
    end else if (w_ref_ev) begin
      r_win_open <= (WIN > 1);
      r_win_cnt  <= CNT_W'(1);
      r_pass     <= w_sclk_ev;
    end else if (w_close) begin
      r_win_open <= 1'b0;
    end else if (iE && r_win_open) begin
      r_win_cnt  <= r_win_cnt + CNT_W'(1);
      r_pass     <= w_bit;
    end
  end

  // Frame alignment: slot index advances per reference edge, ring-start must land on the wrap.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_frame_fault = 1'b0;
    if (w_ref_ev) begin
      case (r_state)
        SEEK: begin
          if (w_st) begin
            w_state_nxt = CAPT;
            w_idx_nxt   = '0;
          end
        end
        CAPT: begin
          if (r_idx == LAST_IDX) begin
            if (w_st) begin
              w_idx_nxt = '0;
            end else begin
              w_frame_fault = 1'b1;
              w_state_nxt   = SEEK;
            end
          end else if (w_st) begin
            w_frame_fault = 1'b1;
            w_state_nxt   = SEEK;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        default: w_state_nxt = SEEK;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= SEEK;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_mask        = r_frame;
    w_mask[r_idx] = w_bit;
  end

  assign w_publish = w_close & (r_state == CAPT) & (r_idx == LAST_IDX) & (w_state_nxt == CAPT);
  assign w_fault   = w_stray | w_early | w_frame_fault;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_frame <= '0;
      oMASK   <= '0;
      oVALID  <= 1'b0;
      oCHG    <= 1'b0;
      oLOCK   <= 1'b0;
      oERR    <= 1'b0;
    end else begin
      if (w_close && (r_state == CAPT)) r_frame <= w_mask;
      if (w_publish) oMASK <= w_mask;
      oVALID <= w_publish;
      oCHG   <= w_publish & (~oLOCK | (w_mask != oMASK));
      oLOCK  <= (w_state_nxt == CAPT) & (oLOCK | w_publish);
      oERR   <= w_fault | (oERR & ~iCLR);
    end
  end

endmodule
